// File: rtl/width_conv_pkg.sv
// Shared definitions for the width_conv_arb block.
//   arb_state_t : sequencer states (IDLE picks an owner, LOCK holds it for the second byte)
//   BYTE_W      : requester / converter byte width
//   PAD_DEFAULT : default byte injected when an owner stalls too long
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package width_conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PAD_DEFAULT = 8'h00;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req     in  N    request vector
//   ptr     in  IW   highest-priority index for this pick
//   gnt     out N    one-hot grant (all zero when no request)
//   gnt_idx out IW   index of the granted request (0 when no request)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  // Search upward from ptr with wrap; the first requester found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/width_conv_arb.sv
// Round-robin arbiter/sequencer sharing one 8-to-16 converter between
// NUM_REQ byte-stream requesters. Each grant covers exactly two bytes
// (high then low) so a converted word never mixes sources; a stalled owner
// gets a PAD byte after TIMEOUT idle cycles to keep the converter's pair
// phase aligned.
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset (shared with converter)
//   arb_en      in   allows new pairs to be granted
//   req_valid   in   NUM_REQ  per-requester byte valid
//   req_data    in   8*NUM_REQ per-requester byte, requester i at [8i+7:8i]
//   req_ready   out  NUM_REQ  combinational accept (only winner/owner)
//   conv_valid  out  converter valid_in, registered
//   conv_data   out  converter data_in, registered
//   word_valid  out  aligned with converter valid_out
//   word_id     out  source of the current word
//   word_padded out  current word's low byte was a pad
//   err_timeout out  pulse in the cycle a pad is taken
module width_conv_arb
  import width_conv_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter int                TIMEOUT = 16,
  parameter logic [BYTE_W-1:0] PAD     = PAD_DEFAULT,
  localparam int               ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arb_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        conv_valid,
  output logic [BYTE_W-1:0]           conv_data,
  output logic                        word_valid,
  output logic [ID_W-1:0]             word_id,
  output logic                        word_padded,
  output logic                        err_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_t          state, state_next;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     rr_ptr;
  logic [7:0]          idle_cnt;
  logic [7:0]          idle_cnt_inc;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic [BYTE_W-1:0]   req_byte [NUM_REQ];

  logic [NUM_REQ-1:0]  ready;
  logic                take;
  logic [BYTE_W-1:0]   take_byte;
  logic                pair_done;
  logic                pad_take;

  logic                s1_valid;
  logic [ID_W-1:0]     s1_id;
  logic                s1_padded;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Saturating so a huge stall can never wrap back below TIMEOUT.
  assign idle_cnt_inc = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

  always_comb begin
    state_next = state;
    ready      = '0;
    take       = 1'b0;
    take_byte  = '0;
    pair_done  = 1'b0;
    pad_take   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_en && (|req_valid)) begin
          ready      = gnt;
          take       = 1'b1;
          take_byte  = req_byte[gnt_idx];
          state_next = LOCK;
        end
      end
      LOCK: begin
        ready[owner] = 1'b1;
        // A real byte in the timeout cycle takes priority over the pad.
        if (req_valid[owner]) begin
          take       = 1'b1;
          take_byte  = req_byte[owner];
          pair_done  = 1'b1;
          state_next = IDLE;
        end else if (idle_cnt_inc == TIMEOUT_CNT) begin
          take       = 1'b1;
          take_byte  = PAD;
          pad_take   = 1'b1;
          pair_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign req_ready   = rst_n ? ready : '0;
  assign err_timeout = rst_n & pad_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      conv_valid  <= 1'b0;
      conv_data   <= '0;
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      s1_padded   <= 1'b0;
      word_valid  <= 1'b0;
      word_id     <= '0;
      word_padded <= 1'b0;
    end else begin
      state <= state_next;

      if (state == IDLE) begin
        idle_cnt <= '0;
        if (take) owner <= gnt_idx;
      end else if (!take) begin
        idle_cnt <= idle_cnt_inc;
      end

      if (pair_done) rr_ptr <= ID_W'(wrap_inc(int'(owner), NUM_REQ));

      conv_valid <= take;
      if (take) conv_data <= take_byte;

      // Two stages match the converter: byte register here, word register there.
      s1_valid    <= pair_done;
      s1_id       <= owner;
      s1_padded   <= pad_take;
      word_valid  <= s1_valid;
      word_id     <= s1_id;
      word_padded <= s1_padded;
    end
  end

endmodule

// File: doc/width_conv_arb.md
# width_conv_arb

Round-robin arbiter and sequencer that shares one `width_8to16` byte-pair converter between `NUM_REQ` byte-stream requesters. Each grant is atomic for two bytes, high then low, so a 16-bit word never mixes sources. The block also covers for a stalled owner: after `TIMEOUT` idle cycles it injects a pad byte so the converter's internal pair phase stays aligned. It sits between the requester ports and the converter's `valid_in`/`data_in`. It reports the source ID of each converted word in the same cycle as the converter's `valid_out`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: LOCK cycles without an owner byte before a pad is injected, 1..255.
- `PAD`, 8'h00: byte injected on timeout.
- `clk`  in  1  single clock, all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; shared with the converter.
- `arb_en`  in  1  when low, no new pair is granted; a pair already in progress still completes.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  per-requester accept, combinational; reset 0.
- `conv_valid`  out  1  drives the converter's `valid_in`, registered; reset 0.
- `conv_data`  out  8  drives the converter's `data_in`, registered; reset 0.
- `word_valid`  out  1  high in the cycle the converter's `valid_out` is high; reset 0.
- `word_id`  out  $clog2(NUM_REQ)  source of the current word; reset 0.
- `word_padded`  out  1  current word's low byte is `PAD`; reset 0.
- `err_timeout`  out  1  one-cycle pulse when a pad is injected; reset 0.

## Operation
- Two states:
  - IDLE: chooses the next owner.
  - LOCK: holds the owner until its second byte.
- IDLE:
  - If `arb_en` is high and any `req_valid` is high, pick the winner by round-robin starting at `rr_ptr`, searching upward with wrap.
  - Raise `req_ready[winner]` in the same cycle.
  - On the accepting edge, capture the byte and `owner` = winner, clear the timeout counter, go to LOCK.
- LOCK:
  - Only `req_ready[owner]` = 1.
  - If `req_valid[owner]` is high, accept the byte and go to IDLE; `rr_ptr` = (owner+1) mod `NUM_REQ`.
  - Otherwise increment the counter. When the counter equals `TIMEOUT`, take `PAD` as the second byte, pulse `err_timeout`, go to IDLE and advance `rr_ptr` as above.
- An owner byte arriving in the timeout cycle wins: no pad is injected and `err_timeout` stays low.
- In any one cycle, only the winner (IDLE) or the owner (LOCK) sees `req_ready` high; every other requester sees 0.
- `arb_en` is ignored in LOCK.
- With `arb_en` low in IDLE, all `req_ready` are 0 and `rr_ptr` holds.
- Every accepted or padded byte produces exactly one `conv_valid` pulse. Bytes are sent in pairs, first byte then second byte, which keeps the converter's internal pair phase aligned.
- Reset mid-pair: all state clears and the converter resets with it, so no partial word survives.

## Timing
- Cycle t: byte accepted (`req_valid & req_ready`).
- Cycle t+1: `conv_valid` = 1 and `conv_data` = that byte.
- Second byte accepted at t gives converter `valid_out` at t+2, with `data_out` = {first, second}.
- At t+2: `word_valid` = 1, `word_id` = owner, `word_padded` = (second byte was a pad).
  - These come from a 2-stage pipeline of {valid, id, padded} loaded at t.
- Throughput is one byte per cycle. Back-to-back pairs run IDLE→LOCK→IDLE→LOCK… with no bubble.
- `err_timeout` is high in the cycle the pad is taken, i.e. cycle t of the pad byte.
- The timeout counter is 8 bits and saturates; it never wraps.

## Structure
- Shared package `width_conv_pkg` holds:
  - the `arb_state_t` enum {IDLE, LOCK};
  - `BYTE_W` = 8;
  - the default `PAD` constant.
- One sub-module, `rr_arbiter`: parameter `N`; inputs `req[N]` and `ptr`; outputs `gnt` (one-hot) and `gnt_idx`; purely combinational round-robin pick. Instantiated once.
- The top level holds the FSM, `owner`, `rr_ptr`, the timeout counter, the conv output registers and the 2-stage word-ID pipeline.

## Test plan
- Single requester: req 2 sends 8'hAB then 8'hCD on consecutive cycles. Required: conv bytes AB, CD; at t+2 `word_valid`=1, `word_id`=2, `word_padded`=0, converter `data_out`=16'hABCD.
- Contention, all four requesters valid continuously from reset: grants in order 0,1,2,3,0 with two bytes each, no interleaving; `word_id` sequence is 0,1,2,3.
- Timeout, `TIMEOUT`=4: req 1 sends 8'h5A then drops valid. Required: pad on the 4th idle LOCK cycle, `err_timeout` pulses once, word 16'h5A00 with `word_padded`=1, `rr_ptr` → 2.
- Late byte: owner presents its byte exactly on the timeout cycle. Required: real byte accepted, no pad, no `err_timeout`.
- `arb_en` dropped in LOCK after the first byte: the pair completes. Afterwards `req_ready` = 0 while low; granting resumes at the advanced `rr_ptr` once it is raised again.
- Reset asserted in LOCK: all outputs 0 immediately. After release, a fresh pair from req 3 produces a correct word, proving the converter phase is realigned.
